// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the simplified multicycle MIPS
// datapath. Sequences fetch/decode/execute/memory/write-back, stalls on the
// memory ready handshake, traps illegal opcodes and counts retired instructions.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   PCWriteCond,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   ALUSrcA,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUSrcB,
  output logic                   ALUOp1,
  output logic                   ALUOp0,
  output logic                   illegal_op,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_COMPL   = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    TRAP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur_state;
  state_t nxt_state;
  logic   retire;

  assign state = cur_state;

  // An instruction retires when a completing state hands control back to FETCH
  assign retire = (nxt_state == FETCH) &&
                  (cur_state inside {MEM_WB, MEM_WRITE, R_COMPL, BRANCH, JUMP});

  // State register, asynchronously forced to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // Retired-instruction counter, wraps naturally at 2^COUNT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
  end

  // Next-state logic
  always_comb begin
    nxt_state = IDLE;
    unique case (cur_state)
      IDLE:      nxt_state = FETCH;
      FETCH:     nxt_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = MEM_ADDR;
          OP_RTYPE:     nxt_state = EXECUTE;
          OP_BEQ:       nxt_state = BRANCH;
          OP_J:         nxt_state = JUMP;
          default:      nxt_state = TRAP;
        endcase
      end
      // opcode is stable here; anything other than lw is treated as sw
      MEM_ADDR:  nxt_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt_state = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt_state = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt_state = R_COMPL;
      MEM_WB, R_COMPL, BRANCH, JUMP, TRAP: nxt_state = FETCH;
      default:   nxt_state = IDLE;
    endcase
  end

  // Moore output decode; only IRWrite/PCWrite in FETCH look at mem_ready
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp1      = 1'b0;
    ALUOp0      = 1'b0;
    illegal_op  = 1'b0;
    case (cur_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp1  = 1'b1;
      end
      R_COMPL: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp0      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      TRAP: begin
        illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed plus randomized instruction stream checked
// against an instruction-level model of the control sequence.
module tb_multicycle_control;

  localparam int CW = 4;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                 S_MEM_READ = 4, S_MEM_WB = 5, S_MEM_WRITE = 6, S_EXECUTE = 7,
                 S_R_COMPL = 8, S_BRANCH = 9, S_JUMP = 10, S_TRAP = 11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic          IRWrite, RegWrite, RegDst, ALUSrcA, ALUOp1, ALUOp0, illegal_op;
  logic [1:0]    PCSource, ALUSrcB;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned model_count = 0;

  multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,
  //  RegDst,ALUSrcA,PCSource,ALUSrcB,ALUOp1,ALUOp0,illegal_op}
  wire [16:0] ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                      IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB,
                      ALUOp1, ALUOp0, illegal_op};

  // Control word the datapath should see in a given step of an instruction
  function automatic logic [16:0] spec_ctrl(input int st, input logic mr);
    logic pcwc, pcw, iord, mrd, mwr, m2r, irw, rw, rd, asa, op1, op0, ill;
    logic [1:0] pcs, asb;
    {pcwc, pcw, iord, mrd, mwr, m2r, irw, rw, rd, asa, op1, op0, ill} = '0;
    pcs = 2'b00;
    asb = 2'b00;
    if (st == S_FETCH)     begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
    if (st == S_DECODE)    asb = 2'b11;
    if (st == S_MEM_ADDR)  begin asa = 1; asb = 2'b10; end
    if (st == S_MEM_READ)  begin mrd = 1; iord = 1; end
    if (st == S_MEM_WB)    begin rw = 1; m2r = 1; end
    if (st == S_MEM_WRITE) begin mwr = 1; iord = 1; end
    if (st == S_EXECUTE)   begin asa = 1; op1 = 1; end
    if (st == S_R_COMPL)   begin rw = 1; rd = 1; end
    if (st == S_BRANCH)    begin asa = 1; op0 = 1; pcwc = 1; pcs = 2'b01; end
    if (st == S_JUMP)      begin pcw = 1; pcs = 2'b10; end
    if (st == S_TRAP)      ill = 1;
    return {pcwc, pcw, iord, mrd, mwr, m2r, irw, rw, rd, asa, pcs, asb, op1, op0, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs (just after posedge), check at negedge
  task automatic step(input int exp_st, input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode = (exp_st == S_DECODE || exp_st == S_MEM_ADDR) ? op : 6'($urandom);
    @(negedge clk);
    chk("state", 32'(state), 32'(exp_st));
    chk($sformatf("ctrl_st%0d", exp_st), 32'(ctrl), 32'(spec_ctrl(exp_st, mr)));
    chk("count_hold", 32'(instr_count), 32'(model_count));
    @(posedge clk);
    #1;
  endtask

  // Build the expected step list for one instruction from the ISA rules,
  // run it, then confirm return to FETCH and the retirement count.
  task automatic run_instr(input logic [5:0] op, input int unsigned fs,
                           input int unsigned ms, input int exp_lat);
    int   st_q[$];
    logic mr_q[$];
    bit   retire;
    retire = 1;
    for (int unsigned i = 0; i < fs; i++) begin st_q.push_back(S_FETCH); mr_q.push_back(0); end
    st_q.push_back(S_FETCH);  mr_q.push_back(1);
    st_q.push_back(S_DECODE); mr_q.push_back(1'($urandom));
    case (op)
      OP_R: begin
        st_q.push_back(S_EXECUTE); mr_q.push_back(1'($urandom));
        st_q.push_back(S_R_COMPL); mr_q.push_back(1'($urandom));
      end
      OP_LW: begin
        st_q.push_back(S_MEM_ADDR); mr_q.push_back(1'($urandom));
        for (int unsigned i = 0; i < ms; i++) begin st_q.push_back(S_MEM_READ); mr_q.push_back(0); end
        st_q.push_back(S_MEM_READ); mr_q.push_back(1);
        st_q.push_back(S_MEM_WB);   mr_q.push_back(1'($urandom));
      end
      OP_SW: begin
        st_q.push_back(S_MEM_ADDR); mr_q.push_back(1'($urandom));
        for (int unsigned i = 0; i < ms; i++) begin st_q.push_back(S_MEM_WRITE); mr_q.push_back(0); end
        st_q.push_back(S_MEM_WRITE); mr_q.push_back(1);
      end
      OP_BEQ: begin st_q.push_back(S_BRANCH); mr_q.push_back(1'($urandom)); end
      OP_J:   begin st_q.push_back(S_JUMP);   mr_q.push_back(1'($urandom)); end
      default: begin
        st_q.push_back(S_TRAP); mr_q.push_back(1'($urandom));
        retire = 0;
      end
    endcase
    if (exp_lat > 0)
      chk($sformatf("latency_op%02h", op), 32'(st_q.size() - fs), 32'(exp_lat));
    foreach (st_q[i]) step(st_q[i], mr_q[i], op);
    if (retire) model_count = (model_count + 1) % (1 << CW);
    chk("back_to_fetch", 32'(state), 32'(S_FETCH));
    chk($sformatf("count_op%02h", op), 32'(instr_count), 32'(model_count));
  endtask

  initial begin
    logic [5:0] legal[5];
    logic [5:0] op;
    legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};

    // Reset asserted from time zero
    rst_n = 1'b0;
    opcode = '0;
    mem_ready = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_ctrl", 32'(ctrl), 32'(0));
    chk("rst_count", 32'(instr_count), 32'(0));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_fetch", 32'(state), 32'(S_FETCH));

    // Directed instructions: R-type, lw with 3 read stalls, beq, j, illegal
    run_instr(OP_R, 0, 0, 4);
    run_instr(OP_LW, 0, 3, 8);
    run_instr(OP_BEQ, 0, 0, 3);
    run_instr(OP_J, 0, 0, 3);
    run_instr(6'b111111, 0, 0, 3);
    run_instr(OP_SW, 2, 0, 4);

    // Reset during a stalled sw in MEM_WRITE
    step(S_FETCH, 1'b1, OP_SW);
    step(S_DECODE, 1'b0, OP_SW);
    step(S_MEM_ADDR, 1'b0, OP_SW);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_stall_state", 32'(state), 32'(S_MEM_WRITE));
    chk("sw_stall_memwrite", 32'(MemWrite), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'(0));
    chk("abort_state", 32'(state), 32'(S_IDLE));
    chk("abort_ctrl", 32'(ctrl), 32'(0));
    chk("abort_count", 32'(instr_count), 32'(0));
    model_count = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_refetch", 32'(state), 32'(S_FETCH));

    // Randomized stream, long enough to wrap the 4-bit counter
    for (int n = 0; n < 45; n++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else                           op = legal[$urandom_range(0, 4)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
